// File: rtl/increase_pulse_gen.sv
// increase_pulse_gen: button synchronizer, debouncer and Increase strobe generator.
// Optional auto-repeat while the button is held: define INCREASE_AUTO_REPEAT_EN.
// Clock domain: Clock (rising edge). Reset: asynchronous, active low.
module increase_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8,
  parameter int CNT_W           = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Button,
  output logic Increase,
  output logic Held
);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;

  // cnt == DEB_LAST is the same test as cnt+1 == DEBOUNCE_CYCLES, without the carry bit
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // a one-sample debounce skips both intermediate states
  localparam bit               DEB_ONE  = (DEBOUNCE_CYCLES == 1);

  state_t           state, state_nx;
  logic             s1, s2;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             inc_nx;
  logic             held_nx;
  logic             rpt_fire;

  // two-flop synchronizer for the asynchronous key level
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= Button;
      s2 <= s1;
    end
  end

`ifdef INCREASE_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rcnt;
  logic             rpt_seen;

  // the first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD
  assign rpt_fire = rpt_seen ? (rcnt == RPT_NEXT) : (rcnt == RPT_FIRST);

  // repeat counter: restarts on a fresh press, frozen during release debounce
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rcnt     <= '0;
      rpt_seen <= 1'b0;
    end else if (state_nx == IDLE) begin
      rcnt     <= '0;
      rpt_seen <= 1'b0;
    end else if ((state == IDLE || state == DEB_PRESS) && state_nx == PRESSED) begin
      rcnt     <= '0;
    end else if (state == PRESSED && s2) begin
      if (rpt_fire) begin
        rcnt     <= '0;
        rpt_seen <= 1'b1;
      end else begin
        rcnt     <= rcnt + 1'b1;
      end
    end
  end
`else
  // repeat timing parameters have no effect in this build
  logic rpt_cfg_unused;
  assign rpt_cfg_unused = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
  assign rpt_fire       = 1'b0;
`endif

  // state and shared debounce counter registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // next-state, debounce counting and strobe decision
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    inc_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (s2) begin
          if (DEB_ONE) begin
            state_nx = PRESSED;
            inc_nx   = 1'b1;
            cnt_nx   = '0;
          end else begin
            state_nx = DEB_PRESS;
            cnt_nx   = CNT_W'(1);
          end
        end else begin
          cnt_nx = '0;
        end
      end
      DEB_PRESS: begin
        if (!s2) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nx = PRESSED;
          inc_nx   = 1'b1;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s2) begin
          if (DEB_ONE) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            state_nx = DEB_RELEASE;
            cnt_nx   = CNT_W'(1);
          end
        end else if (rpt_fire) begin
          inc_nx = 1'b1;
        end
      end
      DEB_RELEASE: begin
        if (s2) begin
          // release rejected: back to held, no new pulse
          state_nx = PRESSED;
          cnt_nx   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign held_nx = (state_nx == PRESSED) || (state_nx == DEB_RELEASE);

  // registered outputs, decoded from the next state so they align with it
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Increase <= 1'b0;
      Held     <= 1'b0;
    end else begin
      Increase <= inc_nx;
      Held     <= held_nx;
    end
  end

endmodule

// File: tb/tb_increase_pulse_gen.sv
// Directed bench for increase_pulse_gen: default instance plus a DEBOUNCE_CYCLES=1 instance.
// Expected auto-repeat pulses follow INCREASE_AUTO_REPEAT_EN when it is defined.
module tb_increase_pulse_gen;

`ifdef INCREASE_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic Clock, Reset, Button, Increase, Held;
  logic b1, inc1, held1;
  int   vectors = 0;
  int   errors  = 0;

  increase_pulse_gen dut (
    .Clock(Clock), .Reset(Reset), .Button(Button), .Increase(Increase), .Held(Held)
  );

  increase_pulse_gen #(.DEBOUNCE_CYCLES(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .Button(b1), .Increase(inc1), .Held(held1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // one bit comparison with failure accounting
  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // hand-computed pulse positions for a long hold (pulse offsets 0,16,24,32,40,48 from edge 5)
  function automatic logic rpt_exp(input int i);
    if (i == 5) return 1'b1;
    if (!AR)    return 1'b0;
    return (i == 21) || (i == 29) || (i == 37) || (i == 45) || (i == 53);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: timeout expired before summary");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [4:0] pat;
    Reset  = 1'b0;
    Button = 1'b0;
    b1     = 1'b0;

    // reset state
    tick();
    tick();
    chk("reset Increase", Increase, 1'b0);
    chk("reset Held", Held, 1'b0);
    chk("reset dut1 Increase", inc1, 1'b0);
    chk("reset dut1 Held", held1, 1'b0);
    Reset = 1'b1;
    repeat (3) tick();

    // clean press: first high sample at edge 0, pulse at edge 5
    Button = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("clean Increase @%0d", i), Increase, logic'(i == 5));
      chk($sformatf("clean Held @%0d", i), Held, logic'(i >= 5));
    end
    Button = 1'b0;
    for (int i = 20; i < 30; i++) begin
      tick();
      chk($sformatf("clean rel Increase @%0d", i), Increase, logic'(AR && i == 21));
      chk($sformatf("clean rel Held @%0d", i), Held, logic'(i < 25));
    end
    repeat (4) tick();

    // bouncy press 1,0,1,1,0 then low: never accepted
    pat = 5'b01101;
    for (int j = 0; j < 13; j++) begin
      Button = (j < 5) ? pat[j] : 1'b0;
      tick();
      chk($sformatf("bounce Increase @%0d", j), Increase, 1'b0);
      chk($sformatf("bounce Held @%0d", j), Held, 1'b0);
    end
    repeat (4) tick();

    // release glitch: two low samples at edges 10,11 are rejected
    Button = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) Button = 1'b0;
      if (i == 12) Button = 1'b1;
      tick();
      chk($sformatf("glitch Increase @%0d", i), Increase, logic'(i == 5));
      chk($sformatf("glitch Held @%0d", i), Held, logic'(i >= 5));
    end
    Button = 1'b0;
    for (int i = 20; i < 30; i++) begin
      tick();
      chk($sformatf("glitch rel Increase @%0d", i), Increase, 1'b0);
      chk($sformatf("glitch rel Held @%0d", i), Held, logic'(i < 25));
    end
    repeat (4) tick();

    // long hold: single pulse, or repeat train when auto-repeat is built
    Button = 1'b1;
    for (int i = 0; i < 55; i++) begin
      tick();
      chk($sformatf("hold Increase @%0d", i), Increase, rpt_exp(i));
      chk($sformatf("hold Held @%0d", i), Held, logic'(i >= 5));
    end
    Button = 1'b0;
    for (int i = 55; i < 66; i++) begin
      tick();
      chk($sformatf("hold rel Increase @%0d", i), Increase, 1'b0);
      chk($sformatf("hold rel Held @%0d", i), Held, logic'(i < 60));
    end
    repeat (4) tick();

    // reset during the Increase-high cycle, button kept high through release
    Button = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rst pre Increase @%0d", i), Increase, logic'(i == 5));
      chk($sformatf("rst pre Held @%0d", i), Held, logic'(i == 5));
    end
    #2;
    Reset = 1'b0;
    #1;
    chk("rst async Increase", Increase, 1'b0);
    chk("rst async Held", Held, 1'b0);
    tick();
    chk("rst hold Increase", Increase, 1'b0);
    chk("rst hold Held", Held, 1'b0);
    tick();
    Reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rst post Increase @%0d", i), Increase, logic'(i == 5));
      chk($sformatf("rst post Held @%0d", i), Held, logic'(i >= 5));
    end
    Button = 1'b0;
    repeat (10) tick();

    // DEBOUNCE_CYCLES=1: single-sample press pulses at edge 2
    b1 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) b1 = 1'b0;
      chk($sformatf("min Increase @%0d", i), inc1, logic'(i == 2));
      chk($sformatf("min Held @%0d", i), held1, logic'(i == 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
